// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory responder slice.
// Holds the FSM state encoding, the request opcode and the request decoder.
package mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } op_t;

    // Both strobes high is illegal and decodes to OP_NONE
    function automatic op_t decode_op(input logic rd, input logic wr);
        op_t op;
        case ({rd, wr})
            2'b10:   op = OP_RD;
            2'b01:   op = OP_WR;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Datapath-to-responder request/response bundle.
// The datapath drives the master side, the responder sits on the slave side.
interface data_mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              read_mem;
    logic              write_mem;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              wr_ack;
    logic              stall;
    logic              err;

    modport master (
        output read_mem, write_mem, addr, wdata,
        input  rdata, rdata_valid, wr_ack, stall, err
    );

    modport slave (
        input  read_mem, write_mem, addr, wdata,
        output rdata, rdata_valid, wr_ack, stall, err
    );

endinterface

// File: rtl/mem_array.sv
// Data storage: synchronous write, combinational read, no reset on contents.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Store port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures one LB/STR request, waits WAIT_CYCLES,
// then commits the store or returns the load byte while stalling the pipeline.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam state_t CAPTURE_NEXT = (WAIT_CYCLES == 0) ? DONE : WAIT;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
    endfunction

    state_t            state_r, state_s;
    op_t               op_r, op_in_s, op_sel_s;
    logic [ADDR_W-1:0] addr_r, addr_sel_s;
    logic [DATA_W-1:0] wdata_r;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] rdata_r, mem_rdata_s;
    logic              rdata_valid_r, wr_ack_r, err_done_r;
    logic              capture_s, stall_s, err_req_s, we_s;
    logic              done_next_s, range_next_s;

    assign op_in_s = decode_op(bus.read_mem, bus.write_mem);

    // In IDLE the access about to start comes straight from the bus
    assign op_sel_s   = (state_r == IDLE) ? op_in_s  : op_r;
    assign addr_sel_s = (state_r == IDLE) ? bus.addr : addr_r;

    // Next-state, counter and per-cycle control
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        stall_s   = 1'b0;
        err_req_s = 1'b0;
        we_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.read_mem && bus.write_mem) begin
                    err_req_s = 1'b1;
                end else if (bus.read_mem || bus.write_mem) begin
                    stall_s   = 1'b1;
                    capture_s = 1'b1;
                    cnt_s     = WAIT_LOAD;
                    state_s   = CAPTURE_NEXT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                stall_s = 1'b1;
                cnt_s   = cnt_r - 4'd1;
                if (cnt_r <= 4'd1) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                we_s    = (op_r == OP_WR) && in_range(addr_r);
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign done_next_s  = (state_s == DONE);
    assign range_next_s = in_range(addr_sel_s);

    mem_array #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (addr_r[IDX_W-1:0]),
        .wdata (wdata_r),
        .raddr (addr_sel_s[IDX_W-1:0]),
        .rdata (mem_rdata_s)
    );

    // State, captured request and DONE-cycle outputs, registered one edge ahead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            op_r          <= OP_NONE;
            addr_r        <= '0;
            wdata_r       <= '0;
            rdata_r       <= '0;
            rdata_valid_r <= 1'b0;
            wr_ack_r      <= 1'b0;
            err_done_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (capture_s) begin
                op_r    <= op_in_s;
                addr_r  <= bus.addr;
                wdata_r <= bus.wdata;
            end
            rdata_valid_r <= done_next_s && (op_sel_s == OP_RD);
            rdata_r       <= (done_next_s && (op_sel_s == OP_RD) && range_next_s)
                             ? mem_rdata_s : '0;
            wr_ack_r      <= done_next_s && (op_sel_s == OP_WR) && range_next_s;
            err_done_r    <= done_next_s && !range_next_s;
        end
    end

    // Same-cycle IDLE responses are masked so reset forces every output low
    assign bus.stall       = rst_n & stall_s;
    assign bus.err         = err_done_r | (rst_n & err_req_s);
    assign bus.rdata       = rdata_r;
    assign bus.rdata_valid = rdata_valid_r;
    assign bus.wr_ack      = wr_ack_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three configurations share one clock and reset,
// each access is checked against a per-instance array model of the storage.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();

    data_mem_responder #(.DEPTH(128), .WAIT_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic       rd_a   [3];
    logic       wr_a   [3];
    logic [7:0] addr_a [3];
    logic [7:0] wd_a   [3];
    logic [11:0] obs_a [3];

    assign bus0.read_mem = rd_a[0]; assign bus0.write_mem = wr_a[0];
    assign bus0.addr = addr_a[0];   assign bus0.wdata = wd_a[0];
    assign bus1.read_mem = rd_a[1]; assign bus1.write_mem = wr_a[1];
    assign bus1.addr = addr_a[1];   assign bus1.wdata = wd_a[1];
    assign bus2.read_mem = rd_a[2]; assign bus2.write_mem = wr_a[2];
    assign bus2.addr = addr_a[2];   assign bus2.wdata = wd_a[2];
    assign obs_a[0] = {bus0.stall, bus0.rdata_valid, bus0.wr_ack, bus0.err, bus0.rdata};
    assign obs_a[1] = {bus1.stall, bus1.rdata_valid, bus1.wr_ack, bus1.err, bus1.rdata};
    assign obs_a[2] = {bus2.stall, bus2.rdata_valid, bus2.wr_ack, bus2.err, bus2.rdata};

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [7:0] a;
        logic [7:0] wd;
    } step_t;

    logic [7:0] mem_m   [3][256];
    bit         known_m [3][256];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 128 : 256;
    endfunction

    // Expected {latency, glitch-before-done flag, stall/valid/ack/err/rdata in final cycle}
    function automatic logic [20:0] exp_vec(input int d, input logic rd, input logic wr,
                                            input logic [7:0] a);
        bit inr;
        inr = (int'(a) < depth_of(d));
        if (rd && wr) return {8'd1, 1'b0, 4'b0001, 8'h00};
        if (rd) return {8'(wait_of(d) + 2), 1'b0, 1'b0, 1'b1, 1'b0, !inr,
                        inr ? mem_m[d][a] : 8'h00};
        return {8'(wait_of(d) + 2), 1'b0, 1'b0, 1'b0, inr, !inr, 8'h00};
    endfunction

    function automatic void apply_model(input int d, input logic rd, input logic wr,
                                        input logic [7:0] a, input logic [7:0] wd);
        if (wr && !rd && (int'(a) < depth_of(d))) begin
            mem_m[d][a]   = wd;
            known_m[d][a] = 1'b1;
        end
    endfunction

    // Drives one request (entered just after a rising edge), holds it until stall drops
    task automatic run_access(input int d, input logic rd, input logic wr, input logic [7:0] a,
                              input logic [7:0] wd, input int chg_cyc, input logic [7:0] chg_a,
                              output logic [20:0] got);
        int cyc;
        bit bad;
        logic [11:0] last;
        rd_a[d] = rd; wr_a[d] = wr; addr_a[d] = a; wd_a[d] = wd;
        cyc = 0; bad = 1'b0; last = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            cyc = i;
            if (obs_a[d][11] == 1'b0) begin
                last = obs_a[d];
                break;
            end
            if (obs_a[d][10:0] != 11'd0) bad = 1'b1;
            @(posedge clk); #1;
            if (i == chg_cyc) begin
                addr_a[d] = chg_a;
                wd_a[d]   = ~wd;
            end
        end
        got = {8'(cyc), bad, last};
        @(posedge clk); #1;
        rd_a[d] = 1'b0; wr_a[d] = 1'b0; addr_a[d] = 8'($urandom); wd_a[d] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd_a[0] = 1'b1; wr_a[0] = 1'b1;
        rd_a[1] = 1'b1;
        wr_a[2] = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (obs_a[d] !== 12'h000) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h want 000", d, obs_a[d]);
            end
        end
        for (int d = 0; d < 3; d++) begin
            rd_a[d] = 1'b0; wr_a[d] = 1'b0;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        step_t st [2] = '{'{1'b0, 1'b1, 8'h10, 8'hA5}, '{1'b1, 1'b0, 8'h10, 8'h00}};
        logic [20:0] got, exp;
        for (int i = 0; i < 2; i++) begin
            exp = exp_vec(0, st[i].rd, st[i].wr, st[i].a);
            run_access(0, st[i].rd, st[i].wr, st[i].a, st[i].wd, 0, 8'h00, got);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL store_load step %0d: got %h want %h", i, got, exp);
            end
            apply_model(0, st[i].rd, st[i].wr, st[i].a, st[i].wd);
        end
    endtask

    task automatic test_back_to_back();
        step_t st [4] = '{'{1'b0, 1'b1, 8'h01, 8'h11}, '{1'b0, 1'b1, 8'h02, 8'h22},
                          '{1'b1, 1'b0, 8'h01, 8'h00}, '{1'b1, 1'b0, 8'h02, 8'h00}};
        logic [20:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            exp = exp_vec(1, st[i].rd, st[i].wr, st[i].a);
            run_access(1, st[i].rd, st[i].wr, st[i].a, st[i].wd, 0, 8'h00, got);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %h want %h", i, got, exp);
            end
            apply_model(1, st[i].rd, st[i].wr, st[i].a, st[i].wd);
        end
    endtask

    task automatic test_illegal();
        step_t st [3] = '{'{1'b0, 1'b1, 8'h05, 8'h5A}, '{1'b1, 1'b1, 8'h05, 8'hC3},
                          '{1'b1, 1'b0, 8'h05, 8'h00}};
        logic [20:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            exp = exp_vec(0, st[i].rd, st[i].wr, st[i].a);
            run_access(0, st[i].rd, st[i].wr, st[i].a, st[i].wd, 0, 8'h00, got);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL illegal step %0d: got %h want %h", i, got, exp);
            end
            apply_model(0, st[i].rd, st[i].wr, st[i].a, st[i].wd);
        end
    endtask

    task automatic test_out_of_range();
        step_t st [6] = '{'{1'b0, 1'b1, 8'h90, 8'hFF}, '{1'b1, 1'b0, 8'h90, 8'h00},
                          '{1'b0, 1'b1, 8'h7F, 8'h66}, '{1'b1, 1'b0, 8'h7F, 8'h00},
                          '{1'b0, 1'b1, 8'h80, 8'h44}, '{1'b1, 1'b0, 8'h80, 8'h00}};
        logic [20:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            exp = exp_vec(0, st[i].rd, st[i].wr, st[i].a);
            run_access(0, st[i].rd, st[i].wr, st[i].a, st[i].wd, 0, 8'h00, got);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL out_of_range step %0d: got %h want %h", i, got, exp);
            end
            apply_model(0, st[i].rd, st[i].wr, st[i].a, st[i].wd);
        end
    endtask

    task automatic test_wait_change();
        step_t st [3] = '{'{1'b0, 1'b1, 8'h21, 8'h99}, '{1'b0, 1'b1, 8'h20, 8'h3C},
                          '{1'b1, 1'b0, 8'h20, 8'h00}};
        logic [20:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            exp = exp_vec(2, st[i].rd, st[i].wr, st[i].a);
            run_access(2, st[i].rd, st[i].wr, st[i].a, st[i].wd, 2, 8'h21, got);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wait_change step %0d: got %h want %h", i, got, exp);
            end
            apply_model(2, st[i].rd, st[i].wr, st[i].a, st[i].wd);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [20:0] got, exp;
        exp = exp_vec(0, 1'b0, 1'b1, 8'h30);
        run_access(0, 1'b0, 1'b1, 8'h30, 8'h12, 0, 8'h00, got);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_store preload: got %h want %h", got, exp);
        end
        apply_model(0, 1'b0, 1'b1, 8'h30, 8'h12);
        wr_a[0] = 1'b1; addr_a[0] = 8'h30; wd_a[0] = 8'h77;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs_a[0] !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_store in_reset: got %h want 000", obs_a[0]);
        end
        @(posedge clk); @(negedge clk);
        n_tests++;
        if (obs_a[0] !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_store held_reset: got %h want 000", obs_a[0]);
        end
        wr_a[0] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp = exp_vec(0, 1'b1, 1'b0, 8'h30);
        run_access(0, 1'b1, 1'b0, 8'h30, 8'h00, 0, 8'h00, got);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_store readback: got %h want %h", got, exp);
        end
    endtask

    task automatic test_random();
        logic [20:0] got, exp;
        for (int k = 0; k < 60; k++) begin
            int d;
            int kind;
            logic rd, wr;
            logic [7:0] a, wd;
            d    = $urandom_range(2, 0);
            kind = $urandom_range(7, 0);
            a    = 8'($urandom);
            wd   = 8'($urandom);
            rd   = (kind >= 4) || (kind == 0);
            wr   = (kind < 4);
            if (rd && !wr && (int'(a) < depth_of(d)) && !known_m[d][a]) begin
                rd = 1'b0;
                wr = 1'b1;
            end
            exp = exp_vec(d, rd, wr, a);
            run_access(d, rd, wr, a, wd, 0, 8'h00, got);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random #%0d dut%0d rd=%0b wr=%0b a=%h: got %h want %h",
                         k, d, rd, wr, a, got, exp);
            end
            apply_model(d, rd, wr, a, wd);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rd_a[d] = 1'b0; wr_a[d] = 1'b0; addr_a[d] = 8'h00; wd_a[d] = 8'h00;
            for (int j = 0; j < 256; j++) begin
                mem_m[d][j]   = 8'h00;
                known_m[d][j] = 1'b0;
            end
        end
        rst_n = 1'b1;
        #2;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_illegal();
        test_out_of_range();
        test_wait_change();
        test_reset_mid_store();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, want finish before 200000", $time);
        $fatal(1);
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the core's memory-request strobes `read_mem` and `write_mem`, which the instruction decoder raises for LB (load) and STR (store).
- Captures the address and write data, inserts a configurable number of wait states, then either commits the store or returns the load byte.
- Holds the pipeline with `stall` for the whole access.
- Sits between the datapath and the on-chip data storage.

Parameters:
- DATA_W, 8, width of a memory word (one byte per LB/STR).
- ADDR_W, 8, address width.
- DEPTH, 256, number of implemented words; must be ≤ 2**ADDR_W.
- WAIT_CYCLES, 1, wait states inserted between request capture and completion; range 0..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- read_mem  in  1  load request, level, held by the datapath until released by stall.
- write_mem  in  1  store request, level, held by the datapath until released by stall.
- addr  in  ADDR_W  byte address; sampled only at request capture.
- wdata  in  DATA_W  store data; sampled only at request capture.
- rdata  out  DATA_W  load result; valid only while rdata_valid=1.
- rdata_valid  out  1  one-cycle pulse: rdata holds the load result.
- wr_ack  out  1  one-cycle pulse: store committed this cycle.
- stall  out  1  datapath must hold the current instruction and its request.
- err  out  1  one-cycle pulse: illegal request or out-of-range address.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0: state=IDLE, rdata=0, rdata_valid=0, wr_ack=0, stall=0, err=0, wait counter=0.
- Storage contents are not cleared by reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If exactly one of read_mem/write_mem is high:
    - stall=1 combinationally in that same cycle.
    - On the edge, latch addr, wdata and op type.
    - Load wait counter with WAIT_CYCLES.
    - Go to WAIT, or straight to DONE if WAIT_CYCLES=0.
  - If both are high: illegal. err=1 for that cycle, stall=0, no access, stay IDLE.
  - If neither is high: stall=0.
- WAIT:
  - stall=1; counter decrements each cycle.
  - When the counter reaches 1, the next state is DONE.
  - Inputs are ignored; changes to addr/wdata are not seen.
- DONE (exactly one cycle, stall=0, so the datapath advances at the end of this cycle):
  - Read: rdata=mem[latched addr], rdata_valid=1.
  - Write: mem[latched addr] is written at the closing edge; wr_ack=1.
  - Request inputs are ignored in DONE; the still-asserted old request is not restarted. Next state is IDLE.
- Latency: request-present cycle to DONE inclusive is WAIT_CYCLES+2 cycles; back-to-back accesses are each WAIT_CYCLES+2 cycles apart.
- Out-of-range (latched addr ≥ DEPTH):
  - In DONE, err=1.
  - Read returns rdata=0 with rdata_valid=1.
  - Write is dropped with wr_ack=0.
- Reset mid-operation: aborts immediately; a pending store is not committed; outputs return to reset values.
- rdata is 0 in every cycle where rdata_valid=0.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE/WAIT/DONE);
  - an op typedef (OP_NONE/OP_RD/OP_WR);
  - default DATA_W/ADDR_W constants.
- One natural sub-module, mem_array: synchronous-write, combinational-read storage with DEPTH×DATA_W, ports we/waddr/wdata/raddr/rdata.
- The FSM, counter and range check stay in data_mem_responder.

Test Plan:
- Store then load, WAIT_CYCLES=1:
  - Stimulus: write_mem=1, addr=0x10, wdata=0xA5, held until stall drops; then read_mem=1, addr=0x10.
  - Response: stall high 2 cycles, wr_ack pulse in the 3rd cycle; rdata=0xA5 with rdata_valid in the 3rd cycle of the read.
- WAIT_CYCLES=0 back-to-back:
  - Stimulus: stores to 0x01=0x11 and 0x02=0x22, then loads of both.
  - Response: each access takes exactly 2 cycles; loads return 0x11, 0x22.
- Illegal request:
  - Stimulus: read_mem=write_mem=1, addr=0x05.
  - Response: err pulse, stall=0, no wr_ack/rdata_valid; mem[0x05] unchanged on a later read.
- Out-of-range, DEPTH=128:
  - Stimulus: store 0xFF to addr=0x90, then load 0x90.
  - Response: err in DONE both times, no wr_ack, load rdata=0 with rdata_valid=1.
- Input change during WAIT, WAIT_CYCLES=3:
  - Stimulus: load 0x20 (preloaded 0x3C); change addr to 0x21 in the 2nd WAIT cycle.
  - Response: rdata=0x3C after 5 cycles.
- Reset mid-store:
  - Stimulus: store 0x77 to 0x30 (0x30 preloaded 0x12); drop rst_n during WAIT; release; load 0x30.
  - Response: outputs 0 during reset, rdata=0x12 afterwards.
